// File: rtl/mesh_input_unit.sv
// Per-port ingress stage of a MESH router.
// Incoming flits are queued in a small FIFO. The oldest flit moves into a head
// register, where its XY route is resolved into a one-hot request for the
// switch controller. A grant releases the head flit to the crossbar.
module mesh_input_unit #(
    parameter int RADIX  = 5,
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int X_W    = 4,
    parameter int Y_W    = 4,
    parameter int X_LOC  = 0,
    parameter int Y_LOC  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_data_val,
    output logic              o_en,
    output logic [0:RADIX-1]  o_output_req,
    input  logic              i_output_grant,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_val,
    output logic              o_error
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [X_W-1:0]   X_HERE  = X_W'(X_LOC);
    localparam logic [Y_W-1:0]   Y_HERE  = Y_W'(Y_LOC);

    // Port indices in [c,n,e,s,w] order
    localparam int PORT_C = 0;
    localparam int PORT_N = 1;
    localparam int PORT_E = 2;
    localparam int PORT_S = 3;
    localparam int PORT_W = 4;

    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              head_val;
    logic [DATA_W-1:0] head_data;
    logic [0:RADIX-1]  head_route;

    logic [DATA_W-1:0] pop_flit;
    logic [X_W-1:0]    dest_x;
    logic [Y_W-1:0]    dest_y;
    logic [0:RADIX-1]  route_oh;

    logic push;
    logic overflow;
    logic pop;
    logic grant_ok;
    logic bad_grant;

    // Upstream may send whenever there is room; held low throughout reset
    assign o_en      = !reset && (count < DEPTH_C);
    assign push      = i_data_val && o_en;
    assign overflow  = i_data_val && !o_en;
    assign grant_ok  = i_output_grant && head_val;
    assign bad_grant = i_output_grant && !head_val;
    assign pop       = (count != '0) && (!head_val || i_output_grant);

    assign pop_flit = fifo_mem[rd_ptr];
    assign dest_x   = pop_flit[DATA_W-1 -: X_W];
    assign dest_y   = pop_flit[DATA_W-X_W-1 -: Y_W];

    // FIFO occupancy and pointers; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are meaningless while the count says empty, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= i_data;
        end
    end

    // XY dimension-order route for the flit about to be popped
    always_comb begin
        route_oh = '0;
        if (dest_x > X_HERE) begin
            route_oh[PORT_E] = 1'b1;
        end else if (dest_x < X_HERE) begin
            route_oh[PORT_W] = 1'b1;
        end else if (dest_y > Y_HERE) begin
            route_oh[PORT_N] = 1'b1;
        end else if (dest_y < Y_HERE) begin
            route_oh[PORT_S] = 1'b1;
        end else begin
            route_oh[PORT_C] = 1'b1;
        end
    end

    // Head register: reload from FIFO when empty or being granted, else drop on grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_val   <= 1'b0;
            head_data  <= '0;
            head_route <= '0;
        end else if (pop) begin
            head_val   <= 1'b1;
            head_data  <= pop_flit;
            head_route <= route_oh;
        end else if (grant_ok) begin
            head_val   <= 1'b0;
        end
    end

    // Sticky protocol-violation flag: overflowing push or grant with no head flit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_error <= 1'b0;
        end else if (overflow || bad_grant) begin
            o_error <= 1'b1;
        end
    end

    assign o_output_req = head_val ? head_route : '0;
    assign o_data       = head_val ? head_data : '0;
    assign o_data_val   = grant_ok;

endmodule

// File: tb/tb_mesh_input_unit.sv
// Directed self-checking bench for mesh_input_unit placed at router (1,1).
module tb_mesh_input_unit;

    logic        clk;
    logic        reset;
    logic [31:0] i_data;
    logic        i_data_val;
    logic        o_en;
    logic [0:4]  o_output_req;
    logic        i_output_grant;
    logic [31:0] o_data;
    logic        o_data_val;
    logic        o_error;

    int errors;
    int checks;

    mesh_input_unit #(
        .RADIX(5), .DEPTH(4), .DATA_W(32), .X_W(4), .Y_W(4), .X_LOC(1), .Y_LOC(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_data(i_data),
        .i_data_val(i_data_val),
        .o_en(o_en),
        .o_output_req(o_output_req),
        .i_output_grant(i_output_grant),
        .o_data(o_data),
        .o_data_val(o_data_val),
        .o_error(o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [3:0] x, input logic [3:0] y, input logic [23:0] p);
        return {x, y, p};
    endfunction

    // advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_data_val = 1'b0;
        i_output_grant = 1'b0;
        i_data = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_data_val = 1'b0;
        i_output_grant = 1'b0;
        i_data = '0;
        tick();
        checks++;
        if (o_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_en: got %b expected 0", o_en); end
        checks++;
        if (o_output_req !== 5'b00000 || o_data_val !== 1'b0 || o_data !== 32'h0 || o_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got req=%b val=%b data=%h err=%b expected all 0",
                     o_output_req, o_data_val, o_data, o_error);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (o_en !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_en: got %b expected 1", o_en); end
    endtask

    task automatic test_grant_invalid();
        i_output_grant = 1'b1;
        #1;
        checks++;
        if (o_data_val !== 1'b0) begin errors++; $display("[TB] FAIL bad_grant_val: got %b expected 0", o_data_val); end
        tick();
        i_output_grant = 1'b0;
        checks++;
        if (o_error !== 1'b1) begin errors++; $display("[TB] FAIL bad_grant_err: got %b expected 1", o_error); end
    endtask

    task automatic test_basic();
        logic [31:0] f;
        f = mk(4'd3, 4'd1, 24'hABCDEF);
        i_data = f;
        i_data_val = 1'b1;
        tick();
        i_data_val = 1'b0;
        checks++;
        if (o_output_req !== 5'b00000) begin errors++; $display("[TB] FAIL basic_no_bypass: got %b expected 00000", o_output_req); end
        tick();
        checks++;
        if (o_output_req !== 5'b00100) begin errors++; $display("[TB] FAIL basic_req: got %b expected 00100", o_output_req); end
        i_output_grant = 1'b1;
        #1;
        checks++;
        if (o_data_val !== 1'b1 || o_data !== f) begin
            errors++;
            $display("[TB] FAIL basic_xfer: got val=%b data=%h expected val=1 data=%h", o_data_val, o_data, f);
        end
        tick();
        i_output_grant = 1'b0;
        #1;
        checks++;
        if (o_output_req !== 5'b00000 || o_data_val !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_after: got req=%b val=%b expected 00000 0", o_output_req, o_data_val);
        end
    endtask

    task automatic test_routing();
        logic [3:0] xs [5];
        logic [3:0] ys [5];
        logic [4:0] exp_req [5];
        xs = '{4'd1, 4'd1, 4'd1, 4'd0, 4'd2};
        ys = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd1};
        exp_req = '{5'b10000, 5'b01000, 5'b00010, 5'b00001, 5'b00100};
        for (int i = 0; i < 5; i++) begin
            i_data = mk(xs[i], ys[i], 24'(i));
            i_data_val = 1'b1;
            tick();
            i_data_val = 1'b0;
            tick();
            checks++;
            if (o_output_req !== exp_req[i]) begin
                errors++;
                $display("[TB] FAIL route_%0d: got %b expected %b", i, o_output_req, exp_req[i]);
            end
            i_output_grant = 1'b1;
            tick();
            i_output_grant = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 10; c++) begin
            i_data_val = (c < 8);
            i_data = mk(4'd2, 4'd1, 24'(c + 24'h100));
            i_output_grant = (c >= 2);
            #1;
            if (c >= 2) begin
                checks++;
                if (o_data_val !== 1'b1 || o_data !== mk(4'd2, 4'd1, 24'(c - 2 + 24'h100))) begin
                    errors++;
                    $display("[TB] FAIL b2b_%0d: got val=%b data=%h expected val=1 data=%h",
                             c, o_data_val, o_data, mk(4'd2, 4'd1, 24'(c - 2 + 24'h100)));
                end
            end
            checks++;
            if (o_en !== 1'b1) begin errors++; $display("[TB] FAIL b2b_en_%0d: got %b expected 1", c, o_en); end
            tick();
        end
        i_data_val = 1'b0;
        i_output_grant = 1'b0;
        tick();
        checks++;
        if (o_output_req !== 5'b00000 || o_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_end: got req=%b err=%b expected 00000 0", o_output_req, o_error);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 5; i++) begin
            i_data = mk(4'd1, 4'd2, 24'(i + 24'h200));
            i_data_val = 1'b1;
            tick();
        end
        checks++;
        if (o_en !== 1'b0) begin errors++; $display("[TB] FAIL fill_en: got %b expected 0", o_en); end
        checks++;
        if (o_error !== 1'b0) begin errors++; $display("[TB] FAIL fill_err_early: got %b expected 0", o_error); end
        i_data = mk(4'd1, 4'd2, 24'hDEAD55);
        tick();
        i_data_val = 1'b0;
        checks++;
        if (o_error !== 1'b1) begin errors++; $display("[TB] FAIL fill_overflow_err: got %b expected 1", o_error); end
        for (int i = 0; i < 5; i++) begin
            i_output_grant = 1'b1;
            #1;
            checks++;
            if (o_data_val !== 1'b1 || o_data !== mk(4'd1, 4'd2, 24'(i + 24'h200))) begin
                errors++;
                $display("[TB] FAIL fill_drain_%0d: got val=%b data=%h expected val=1 data=%h",
                         i, o_data_val, o_data, mk(4'd1, 4'd2, 24'(i + 24'h200)));
            end
            tick();
        end
        i_output_grant = 1'b0;
        tick();
        checks++;
        if (o_output_req !== 5'b00000 || o_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL fill_no_sixth: got req=%b data=%h expected 00000 0", o_output_req, o_data);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            i_data = mk(4'd0, 4'd1, 24'(i + 24'h300));
            i_data_val = 1'b1;
            tick();
        end
        i_data_val = 1'b0;
        i_output_grant = 1'b1;
        reset = 1'b1;
        #1;
        checks++;
        if (o_output_req !== 5'b00000 || o_data_val !== 1'b0 || o_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got req=%b val=%b en=%b expected 00000 0 0",
                     o_output_req, o_data_val, o_en);
        end
        i_output_grant = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (o_en !== 1'b1 || o_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_release: got en=%b err=%b expected 1 0", o_en, o_error);
        end
        tick();
        tick();
        tick();
        checks++;
        if (o_output_req !== 5'b00000 || o_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL mid_stale: got req=%b data=%h expected 00000 0", o_output_req, o_data);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;
        i_data = '0;
        i_data_val = 1'b0;
        i_output_grant = 1'b0;
        test_reset();
        test_grant_invalid();
        do_reset();
        test_basic();
        test_routing();
        test_back_to_back();
        test_fill();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
